// File: rtl/affinex_point_seq.sv
// Point sequencer around the affine core: input FIFO -> start/done handshake -> output FIFO.
// Optional build macro AFFINEX_CLIP_EN saturates stored results to [0,XMAX]/[0,YMAX] and adds a sticky clipped flag.
module affinex_point_seq #(
  parameter int WIDTH   = 16,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 255,
  parameter int XMAX    = 255,
  parameter int YMAX    = 255
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid_i,
  output logic                       in_ready_o,
  input  logic [WIDTH-1:0]           in_x_i,
  input  logic [WIDTH-1:0]           in_y_i,
  output logic                       core_start_o,
  output logic [WIDTH-1:0]           core_x_o,
  output logic [WIDTH-1:0]           core_y_o,
  input  logic                       core_done_i,
  input  logic [WIDTH-1:0]           core_out_x_i,
  input  logic [WIDTH-1:0]           core_out_y_i,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic [WIDTH-1:0]           out_x_o,
  output logic [WIDTH-1:0]           out_y_o,
  output logic [$clog2(DEPTH):0]     in_count_o,
  output logic [$clog2(DEPTH):0]     out_count_o,
  output logic                       busy_o,
  output logic                       err_o,
`ifdef AFFINEX_CLIP_EN
  output logic                       clipped_o,
`endif
  input  logic                       clr_err_i
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, STORE} state_e;

  state_e            state_q;
  logic [TW-1:0]     tcnt_q;
  logic [WIDTH-1:0]  hold_x_q, hold_y_q;
  logic              err_q;

  // Input FIFO
  logic [WIDTH-1:0]  ix_mem [DEPTH];
  logic [WIDTH-1:0]  iy_mem [DEPTH];
  logic [AW-1:0]     iwr_q, ird_q;
  logic [CW-1:0]     icnt_q;

  // Output FIFO
  logic [WIDTH-1:0]  ox_mem [DEPTH];
  logic [WIDTH-1:0]  oy_mem [DEPTH];
  logic [AW-1:0]     owr_q, ord_q;
  logic [CW-1:0]     ocnt_q;

  logic              in_push, in_pop, out_push, out_pop, tmo;
  logic [WIDTH-1:0]  st_x, st_y;
  logic              st_clip;

  assign in_ready_o  = (icnt_q != CW'(DEPTH));
  assign in_push     = in_valid_i & in_ready_o;
  assign tmo         = (state_q == WAIT) & ~core_done_i & (tcnt_q == TW'(TIMEOUT - 1));
  assign in_pop      = (state_q == STORE) | tmo;
  assign out_push    = (state_q == STORE);
  assign out_valid_o = (ocnt_q != '0);
  assign out_pop     = out_valid_o & out_ready_i;

  assign core_x_o    = (icnt_q != '0) ? ix_mem[ird_q] : '0;
  assign core_y_o    = (icnt_q != '0) ? iy_mem[ird_q] : '0;
  assign out_x_o     = out_valid_o ? ox_mem[ord_q] : '0;
  assign out_y_o     = out_valid_o ? oy_mem[ord_q] : '0;
  assign in_count_o  = icnt_q;
  assign out_count_o = ocnt_q;
  assign core_start_o = (state_q == ISSUE);
  assign busy_o      = (state_q != IDLE);
  assign err_o       = err_q;

`ifdef AFFINEX_CLIP_EN
  localparam logic signed [WIDTH-1:0] XLIM = WIDTH'(XMAX);
  localparam logic signed [WIDTH-1:0] YLIM = WIDTH'(YMAX);
  logic clipped_q;
  logic x_lo, x_hi, y_lo, y_hi;

  always_comb begin
    x_lo    = $signed(hold_x_q) < 0;
    x_hi    = $signed(hold_x_q) > XLIM;
    y_lo    = $signed(hold_y_q) < 0;
    y_hi    = $signed(hold_y_q) > YLIM;
    st_x    = x_lo ? '0 : (x_hi ? XLIM : hold_x_q);
    st_y    = y_lo ? '0 : (y_hi ? YLIM : hold_y_q);
    st_clip = x_lo | x_hi | y_lo | y_hi;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                   clipped_q <= 1'b0;
    else if (out_push && st_clip) clipped_q <= 1'b1;
    else if (clr_err_i)           clipped_q <= 1'b0;
  end

  assign clipped_o = clipped_q;
`else
  assign st_x    = hold_x_q;
  assign st_y    = hold_y_q;
  assign st_clip = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (in_push) begin
      ix_mem[iwr_q] <= in_x_i;
      iy_mem[iwr_q] <= in_y_i;
    end
    if (out_push) begin
      ox_mem[owr_q] <= st_x;
      oy_mem[owr_q] <= st_y;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      iwr_q  <= '0;
      ird_q  <= '0;
      icnt_q <= '0;
      owr_q  <= '0;
      ord_q  <= '0;
      ocnt_q <= '0;
    end else begin
      if (in_push)  iwr_q <= iwr_q + AW'(1);
      if (in_pop)   ird_q <= ird_q + AW'(1);
      icnt_q <= icnt_q + CW'(in_push) - CW'(in_pop);
      if (out_push) owr_q <= owr_q + AW'(1);
      if (out_pop)  ord_q <= ord_q + AW'(1);
      ocnt_q <= ocnt_q + CW'(out_push) - CW'(out_pop);
    end
  end

  // Issue only when the output FIFO can absorb the result, so STORE never overflows.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      tcnt_q   <= '0;
      hold_x_q <= '0;
      hold_y_q <= '0;
      err_q    <= 1'b0;
    end else begin
      if (tmo)            err_q <= 1'b1;
      else if (clr_err_i) err_q <= 1'b0;
      case (state_q)
        IDLE: if (icnt_q != '0 && ocnt_q != CW'(DEPTH)) state_q <= ISSUE;
        ISSUE: begin
          tcnt_q  <= '0;
          state_q <= WAIT;
        end
        WAIT: begin
          if (core_done_i) begin
            hold_x_q <= core_out_x_i;
            hold_y_q <= core_out_y_i;
            state_q  <= STORE;
          end else if (tmo) begin
            state_q <= IDLE;
          end else begin
            tcnt_q <= tcnt_q + TW'(1);
          end
        end
        STORE:   state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_affinex_point_seq.sv
// Directed bench for affinex_point_seq with a latency-5 core model returning (x+1, y+2).
module tb_affinex_point_seq;
  localparam int W = 16;
  localparam int D = 4;

  logic clk = 1'b0;
  logic rst_n;
  logic in_valid, in_ready, core_start, core_done, out_valid, out_ready;
  logic busy, err, clr_err;
  logic [W-1:0] in_x, in_y, core_x, core_y, core_out_x, core_out_y, out_x, out_y;
  logic [$clog2(D):0] in_count, out_count;
`ifdef AFFINEX_CLIP_EN
  logic clipped;
`endif

  // Core model state
  logic         core_en, stray;
  logic [2:0]   ccnt;
  logic [W-1:0] cx, cy;

  int ntests = 0;
  int nfail  = 0;

  always #5 clk = ~clk;

  affinex_point_seq #(.WIDTH(W), .DEPTH(D), .TIMEOUT(8), .XMAX(255), .YMAX(255)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .in_x_i(in_x), .in_y_i(in_y),
    .core_start_o(core_start), .core_x_o(core_x), .core_y_o(core_y),
    .core_done_i(core_done), .core_out_x_i(core_out_x), .core_out_y_i(core_out_y),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .out_x_o(out_x), .out_y_o(out_y),
    .in_count_o(in_count), .out_count_o(out_count), .busy_o(busy), .err_o(err),
`ifdef AFFINEX_CLIP_EN
    .clipped_o(clipped),
`endif
    .clr_err_i(clr_err)
  );

  // done is high 5 cycles after the start cycle
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ccnt <= '0; cx <= '0; cy <= '0;
    end else if (core_start) begin
      ccnt <= 3'd1; cx <= core_x; cy <= core_y;
    end else if (ccnt == 3'd5) ccnt <= '0;
    else if (ccnt != '0)       ccnt <= ccnt + 3'd1;
  end
  assign core_done  = (core_en && ccnt == 3'd5) || stray;
  assign core_out_x = cx + 16'd1;
  assign core_out_y = cy + 16'd2;

  typedef struct {
    shortint x, y, ex, ey;
  } vec_t;
  vec_t vt [5];

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic push1(input shortint x, input shortint y);
    in_valid = 1'b1; in_x = x; in_y = y;
    tick;
    in_valid = 1'b0;
  endtask

  task automatic pop1;
    out_ready = 1'b1; tick; out_ready = 1'b0;
  endtask

  task automatic wait_out(input string nm);
    int n = 0;
    while (!out_valid && n < 60) begin tick; n++; end
    if (!out_valid) chk({nm, " timeout"}, 0, 1);
  endtask

  function automatic int sat(input shortint v);
`ifdef AFFINEX_CLIP_EN
    return (v < 0) ? 0 : ((v > 255) ? 255 : int'(v));
`else
    return int'(v);
`endif
  endfunction

  initial begin
    int n, start_cyc, err_cyc;
    vt[0] = '{10, 20, 11, 22};
    vt[1] = '{-1, -2, 0, 0};
    vt[2] = '{100, -100, 101, -98};
    vt[3] = '{32767, 5, -32768, 7};
    vt[4] = '{-300, 32766, -299, -32768};

    rst_n = 1'b0; in_valid = 0; in_x = 0; in_y = 0; out_ready = 0;
    clr_err = 0; core_en = 1; stray = 0;
    repeat (3) tick;
    chk("rst in_count", in_count, 0);
    chk("rst out_count", out_count, 0);
    chk("rst busy", busy, 0);
    chk("rst out_valid", out_valid, 0);
    chk("rst err", err, 0);
    chk("rst core_start", core_start, 0);
    chk("rst core_x", core_x, 0);
    chk("rst out_x", out_x, 0);
    rst_n = 1'b1;
    tick;
    chk("rst in_ready", in_ready, 1);

    // Basic latency: cycle 0 = in_valid
    push1(10, 20);
    chk("lat c1 start", core_start, 0);
    tick;
    chk("lat c2 start", core_start, 1);
    chk("lat c2 core_x", core_x, 10);
    tick;
    chk("lat c3 start", core_start, 0);
    chk("lat c3 busy", busy, 1);
    repeat (5) tick;
    chk("lat c8 out_valid", out_valid, 0);
    tick;
    chk("lat c9 out_valid", out_valid, 1);
    chk("lat out_x", $signed(out_x), 11);
    chk("lat out_y", $signed(out_y), 22);
    chk("lat busy", busy, 0);
    pop1;
    chk("lat popped", out_valid, 0);

    // Table of values
    for (int i = 0; i < 5; i++) begin
      push1(vt[i].x, vt[i].y);
      wait_out("vec");
      chk($sformatf("vec%0d x", i), $signed(out_x), sat(vt[i].ex));
      chk($sformatf("vec%0d y", i), $signed(out_y), sat(vt[i].ey));
      pop1;
    end
    clr_err = 1; tick; clr_err = 0;

    // Streaming with back-pressure
    in_valid = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      in_x = W'(i); in_y = W'(i); tick;
    end
    in_valid = 1'b0;
    chk("strm in_count", in_count, 4);
    chk("strm in_ready", in_ready, 0);
    n = 0;
    while (out_count != 3'd4 && n < 200) begin tick; n++; end
    repeat (5) tick;
    chk("strm out_count", out_count, 4);
    chk("strm in_empty", in_count, 0);
    chk("strm stalled", busy, 0);
    push1(5, 5);
    repeat (4) tick;
    chk("strm held in_count", in_count, 1);
    chk("strm held busy", busy, 0);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("drain%0d x", i), $signed(out_x), i + 2);
      chk($sformatf("drain%0d y", i), $signed(out_y), i + 3);
      pop1;
    end
    chk("drain empty", out_count, 0);
    wait_out("resume");
    chk("resume x", $signed(out_x), 6);
    chk("resume y", $signed(out_y), 7);
    pop1;

    // Timeout
    core_en = 0;
    in_valid = 1'b1; in_x = 7; in_y = 7;
    start_cyc = -1; err_cyc = -1;
    for (int c = 0; c < 30; c++) begin
      if (core_start && start_cyc < 0) start_cyc = c;
      if (err && err_cyc < 0) err_cyc = c;
      tick;
      in_valid = 1'b0;
    end
    chk("tmo start cycle", start_cyc, 2);
    chk("tmo err cycle", err_cyc, 11);
    chk("tmo err", err, 1);
    chk("tmo in_count", in_count, 0);
    chk("tmo out_count", out_count, 0);
    clr_err = 1; tick; clr_err = 0;
    chk("tmo clr", err, 0);
    core_en = 1;

    // Stray done in IDLE and STORE
    stray = 1; tick; stray = 0; tick;
    chk("stray idle out_count", out_count, 0);
    chk("stray idle busy", busy, 0);
    push1(1, 1);
    repeat (7) tick;
    chk("stray store busy", busy, 1);
    chk("stray store out_count", out_count, 0);
    stray = 1; tick; stray = 0;
    chk("stray store push", out_count, 1);
    repeat (3) tick;
    stray = 1; tick; stray = 0; repeat (2) tick;
    chk("stray after out_count", out_count, 1);
    chk("stray x", $signed(out_x), 2);
    pop1;

    // Reset mid-WAIT
    core_en = 0;
    push1(3, 3);
    push1(4, 4);
    repeat (4) tick;
    chk("mid busy", busy, 1);
    rst_n = 1'b0; #1;
    chk("mid in_count", in_count, 0);
    chk("mid out_count", out_count, 0);
    chk("mid busy rst", busy, 0);
    chk("mid core_start", core_start, 0);
    chk("mid out_valid", out_valid, 0);
    tick; rst_n = 1'b1; core_en = 1; tick;

`ifdef AFFINEX_CLIP_EN
    clr_err = 1; tick; clr_err = 0;
    chk("clip pre", clipped, 0);
    push1(299, -7);
    wait_out("clip");
    chk("clip x", $signed(out_x), 255);
    chk("clip y", $signed(out_y), 0);
    chk("clip flag", clipped, 1);
    pop1;
    clr_err = 1; tick; clr_err = 0;
    push1(99, 98);
    wait_out("noclip");
    chk("noclip x", $signed(out_x), 100);
    chk("noclip y", $signed(out_y), 100);
    chk("noclip flag", clipped, 0);
    pop1;
`endif

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule
